port_egress_serializer: RTL
===========================

PORT_EGRESS_SERIALIZER -- requirements
Module: port_egress_serializer

Interface
REQ-001 Parameter DATA_W, 32: width of destination IP, payload and tx_data.
REQ-002 Parameter CRC_LEN, 33: width of the CRC field (DATA_W+1).
REQ-003 Parameter PKT_LEN, 97: packet width, 2*DATA_W+CRC_LEN.
REQ-004 Parameter DEPTH, 4: packet queue depth; SHALL be a power of two, at least 2.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 port_en  input  1  link up for this egress port; low = link down.
REQ-008 pkt_in_vld  input  1  one-cycle strobe: pkt_in holds a routed packet.
REQ-009 pkt_in  input  PKT_LEN  {dest_ip[DATA_W-1:0], payload[DATA_W-1:0], crc[CRC_LEN-1:0]}.
REQ-010 tx_rdy  input  1  downstream accepts the current beat.
REQ-011 tx_vld  output  1  tx_data holds a valid beat.
REQ-012 tx_data  output  DATA_W  beat data.
REQ-013 tx_sop  output  1  first beat of a packet (dest_ip).
REQ-014 tx_eop  output  1  last beat of a packet (payload).
REQ-015 full  output  1  queue holds DEPTH packets.
REQ-016 empty  output  1  queue holds 0 packets.
REQ-017 level  output  $clog2(DEPTH)+1  packets currently queued.
REQ-018 overflow  output  1  one-cycle pulse: an incoming packet was dropped because the queue was full.
REQ-019 drop_cnt  output  8  overflow drops since reset; saturates at 255.

Function
REQ-020 Push: pkt_in_vld=1, port_en=1, registered level<DEPTH -> store dest_ip and payload at the write pointer; the CRC field SHALL be discarded.
REQ-021 Full: pkt_in_vld=1, port_en=1, level==DEPTH -> drop; overflow=1 next cycle; drop_cnt+1 (saturating). A pop in the same cycle SHALL NOT free the slot.
REQ-022 pkt_in_vld while port_en=0 SHALL be ignored: no push, no overflow, no drop_cnt change.
REQ-023 FSM states: IDLE, SEND_IP, SEND_PL.
REQ-024 IDLE -> SEND_IP when level!=0 and port_en=1.
REQ-025 SEND_IP: tx_vld=1, tx_sop=1, tx_eop=0, tx_data=head dest_ip; on tx_rdy=1 -> SEND_PL.
REQ-026 SEND_PL: tx_vld=1, tx_sop=0, tx_eop=1, tx_data=head payload; on tx_rdy=1 -> pop the head; next state SEND_IP if level>1 before the pop, else IDLE.
REQ-027 IDLE: tx_vld=0, tx_sop=0, tx_eop=0, tx_data=0.
REQ-028 While tx_vld=1 and tx_rdy=0, tx_data, tx_sop and tx_eop SHALL hold stable.
REQ-029 Latency: pkt_in_vld in cycle c into an empty idle block -> tx_vld=1 (SEND_IP) in cycle c+2.
REQ-030 Back-to-back: with tx_rdy held high, queued packets stream with no idle cycle between eop and the next sop.
REQ-031 Simultaneous push and pop with level<DEPTH: both take effect; level unchanged.
REQ-032 Pointers SHALL wrap modulo DEPTH; level SHALL stay within 0..DEPTH.
REQ-033 Link down: port_en=0 in any state, including mid-packet -> next cycle the queue is flushed (level=0, pointers=0) and the state is IDLE; tx_vld=0.
REQ-034 Flushed packets SHALL NOT count in drop_cnt.
REQ-035 If port_en=0 and pkt_in_vld=1 arrive together, the flush wins and the packet is ignored.

Reset
REQ-036 rst=1 at a clock edge -> state IDLE, pointers 0, level 0, empty=1, full=0, tx_vld=0, tx_sop=0, tx_eop=0, tx_data=0, overflow=0, drop_cnt=0.
REQ-037 rst SHALL override every other input, including mid-packet; queued packets are discarded.

Verification
REQ-038 Single packet: port_en=1, tx_rdy=1, push {32'hC0A80001, 32'hDEADBEEF, any CRC} -> cycle c+2 tx_data=C0A80001, sop=1; cycle c+3 tx_data=DEADBEEF, eop=1; then empty=1.
REQ-039 Fill and overflow: tx_rdy=0, 5 pushes -> full=1, level=4, one overflow pulse, drop_cnt=1; tx_rdy=1 -> 8 beats of the first 4 packets in order, with no gaps.
REQ-040 Backpressure: tx_rdy toggling 1/0 -> each beat held stable while tx_rdy=0; beat order IP, PL preserved.
REQ-041 Link down mid-packet: port_en=0 during SEND_PL with 3 queued -> next cycle tx_vld=0, level=0, drop_cnt unchanged; port_en=1 and a new push -> normal output at c+2.
REQ-042 Saturation: 300 overflow drops -> drop_cnt=255.
REQ-043 Reset mid-stream: rst=1 during SEND_IP with level=2 -> all outputs take their reset values the next cycle.

Source files
------------

// File: rtl/port_egress_serializer_if.sv
// Handshake bundle for the egress serializer: routed-packet strobe in, beat stream out.
// The master modport is the serializer's view and the slave modport is the peer's view.
interface port_egress_serializer_if #(
  parameter int DATA_W  = 32,
  parameter int PKT_LEN = 97
);
  logic               pkt_in_vld;
  logic [PKT_LEN-1:0] pkt_in;
  logic               tx_rdy;
  logic               tx_vld;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_sop;
  logic               tx_eop;

  modport master (
    input  pkt_in_vld,
    input  pkt_in,
    input  tx_rdy,
    output tx_vld,
    output tx_data,
    output tx_sop,
    output tx_eop
  );

  modport slave (
    output pkt_in_vld,
    output pkt_in,
    output tx_rdy,
    input  tx_vld,
    input  tx_data,
    input  tx_sop,
    input  tx_eop
  );
endinterface

// File: rtl/port_egress_serializer.sv
// Egress port serializer: queues routed packets (CRC stripped) and sends each one
// as two beats, dest_ip (sop) then payload (eop), with overflow drop counting and link-down flush.
module port_egress_serializer #(
  parameter int DATA_W  = 32,
  parameter int CRC_LEN = 33,
  parameter int PKT_LEN = 97,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   port_en,
  port_egress_serializer_if.master bus,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1'b1);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_IP = 2'd1,
    ST_SEND_PL = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_nx_s;
  logic [PTR_W-1:0]   rd_ptr_nx_s;
  logic [LVL_W-1:0]   level_r;
  logic [LVL_W-1:0]   level_nx_s;
  logic               full_r;
  logic               empty_r;
  logic               overflow_r;
  logic [7:0]         drop_cnt_r;
  logic [7:0]         drop_cnt_nx_s;
  logic               tx_vld_r;
  logic               tx_sop_r;
  logic               tx_eop_r;
  logic [DATA_W-1:0]  tx_data_r;
  logic               tx_vld_nx_s;
  logic               tx_sop_nx_s;
  logic               tx_eop_nx_s;
  logic [DATA_W-1:0]  tx_data_nx_s;

  logic               pkt_hit_s;
  logic               push_s;
  logic               drop_s;
  logic               pop_s;
  logic [DATA_W-1:0]  dest_ip_s;
  logic [DATA_W-1:0]  payload_s;
  logic               unused_crc_s;

  logic [DATA_W-1:0]  ip_mem_r [DEPTH];
  logic [DATA_W-1:0]  pl_mem_r [DEPTH];

  assign dest_ip_s    = bus.pkt_in[PKT_LEN-1 -: DATA_W];
  assign payload_s    = bus.pkt_in[CRC_LEN +: DATA_W];
  // The CRC was checked upstream; it is not forwarded on the egress beats.
  assign unused_crc_s = ^bus.pkt_in[CRC_LEN-1:0];

  // Qualify the incoming strobe and the head pop against link state and occupancy.
  always_comb begin
    pkt_hit_s = bus.pkt_in_vld & port_en;
    push_s    = pkt_hit_s & (level_r != LVL_FULL);
    drop_s    = pkt_hit_s & (level_r == LVL_FULL);
    pop_s     = port_en & (state_r == ST_SEND_PL) & bus.tx_rdy;
  end

  // Next FSM state; a dropped link forces IDLE from anywhere.
  always_comb begin
    state_nx_s = ST_IDLE;
    if (!port_en) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (level_r != LVL_ZERO) state_nx_s = ST_SEND_IP;
          else                     state_nx_s = ST_IDLE;
        end
        ST_SEND_IP: begin
          if (bus.tx_rdy) state_nx_s = ST_SEND_PL;
          else            state_nx_s = ST_SEND_IP;
        end
        ST_SEND_PL: begin
          if (bus.tx_rdy) begin
            if (level_r > LVL_ONE) state_nx_s = ST_SEND_IP;
            else                   state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_SEND_PL;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Next queue pointers, occupancy and drop counter.
  always_comb begin
    wr_ptr_nx_s   = wr_ptr_r;
    rd_ptr_nx_s   = rd_ptr_r;
    level_nx_s    = level_r;
    drop_cnt_nx_s = drop_cnt_r;
    if (!port_en) begin
      wr_ptr_nx_s = PTR_ZERO;
      rd_ptr_nx_s = PTR_ZERO;
      level_nx_s  = LVL_ZERO;
    end else begin
      if (push_s) wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
      else        wr_ptr_nx_s = wr_ptr_r;
      if (pop_s)  rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
      else        rd_ptr_nx_s = rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   level_nx_s = level_r + LVL_ONE;
        2'b01:   level_nx_s = level_r - LVL_ONE;
        default: level_nx_s = level_r;
      endcase
    end
    if (drop_s && (drop_cnt_r != 8'hFF)) drop_cnt_nx_s = drop_cnt_r + 8'd1;
    else                                 drop_cnt_nx_s = drop_cnt_r;
  end

  // Beat outputs are looked up from the head slot the next state will present.
  always_comb begin
    tx_vld_nx_s  = 1'b0;
    tx_sop_nx_s  = 1'b0;
    tx_eop_nx_s  = 1'b0;
    tx_data_nx_s = {DATA_W{1'b0}};
    case (state_nx_s)
      ST_IDLE: begin
        tx_vld_nx_s  = 1'b0;
        tx_data_nx_s = {DATA_W{1'b0}};
      end
      ST_SEND_IP: begin
        tx_vld_nx_s  = 1'b1;
        tx_sop_nx_s  = 1'b1;
        tx_data_nx_s = ip_mem_r[rd_ptr_nx_s];
      end
      ST_SEND_PL: begin
        tx_vld_nx_s  = 1'b1;
        tx_eop_nx_s  = 1'b1;
        tx_data_nx_s = pl_mem_r[rd_ptr_nx_s];
      end
      default: begin
        tx_vld_nx_s  = 1'b0;
        tx_data_nx_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Control, status and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      level_r    <= LVL_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
      tx_vld_r   <= 1'b0;
      tx_sop_r   <= 1'b0;
      tx_eop_r   <= 1'b0;
      tx_data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      wr_ptr_r   <= wr_ptr_nx_s;
      rd_ptr_r   <= rd_ptr_nx_s;
      level_r    <= level_nx_s;
      full_r     <= (level_nx_s == LVL_FULL);
      empty_r    <= (level_nx_s == LVL_ZERO);
      overflow_r <= drop_s;
      drop_cnt_r <= drop_cnt_nx_s;
      tx_vld_r   <= tx_vld_nx_s;
      tx_sop_r   <= tx_sop_nx_s;
      tx_eop_r   <= tx_eop_nx_s;
      tx_data_r  <= tx_data_nx_s;
    end
  end

  // Packet storage; only occupied slots are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ip_mem_r[wr_ptr_r] <= dest_ip_s;
      pl_mem_r[wr_ptr_r] <= payload_s;
    end
  end

  assign bus.tx_vld  = tx_vld_r;
  assign bus.tx_sop  = tx_sop_r;
  assign bus.tx_eop  = tx_eop_r;
  assign bus.tx_data = tx_data_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign level       = level_r;
  assign overflow    = overflow_r;
  assign drop_cnt    = drop_cnt_r;

endmodule
